// File: rtl/mmio_out_port_if.sv
// Bus bundle for mmio_out_port: core-side store/read port plus the outbound valid/ready stream.
// The peripheral takes the slave modport; the core and consumer side take the master modport.
interface mmio_out_port_if;
   logic        write;
   logic [31:0] address;
   logic [31:0] write_data;
   logic [31:0] read_data;
   logic        sel;
   logic        out_valid;
   logic [31:0] out_data;
   logic        out_ready;

   modport master (
      output write, address, write_data, out_ready,
      input  read_data, sel, out_valid, out_data
   );

   modport slave (
      input  write, address, write_data, out_ready,
      output read_data, sel, out_valid, out_data
   );
endinterface

// File: rtl/mmio_out_port.sv
// Memory-mapped output port: stores to BASE feed a FIFO drained over valid/ready.
// Define MMIO_CYCLE_COUNTER_EN to implement the CYCLES register at BASE+8.
module mmio_out_port #(
   parameter int unsigned DEPTH = 4,
   parameter logic [31:0] BASE  = 32'hFFFF0000
) (
   input logic             clk,
   input logic             reset,
   mmio_out_port_if.slave  bus
);

   localparam int unsigned     PtrW     = $clog2(DEPTH);
   localparam logic [PtrW:0]   CountMax = (PtrW + 1)'(DEPTH);

   logic [31:0]     mem [DEPTH];
   logic [PtrW-1:0] head_q, tail_q;
   logic [PtrW:0]   count_q;
   logic            ovf_q;

   logic hit_data, hit_status;
   logic empty, full;
   logic push_req, push, pop, drop;
   logic [31:0] status;

   assign hit_data   = (bus.address == BASE);
   assign hit_status = (bus.address == BASE + 32'd4);

   assign empty = (count_q == '0);
   assign full  = (count_q == CountMax);

   assign push_req = bus.write & hit_data;
   assign pop      = ~empty & bus.out_ready;
   // A pop on the same edge frees the slot, so a full FIFO still accepts the push.
   assign push     = push_req & (~full | pop);
   assign drop     = push_req & full & ~pop;

   always_ff @(posedge clk) begin
      if (reset) begin
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
         ovf_q   <= 1'b0;
      end else begin
         if (push) tail_q <= tail_q + PtrW'(1);
         if (pop)  head_q <= head_q + PtrW'(1);
         if (push && !pop) begin
            count_q <= count_q + (PtrW + 1)'(1);
         end else if (pop && !push) begin
            count_q <= count_q - (PtrW + 1)'(1);
         end
         if (bus.write && hit_status) begin
            ovf_q <= 1'b0;
         end else if (drop) begin
            ovf_q <= 1'b1;
         end
      end
   end

   // Storage is not reset; count and pointers alone define what is visible.
   always_ff @(posedge clk) begin
      if (!reset && push) mem[tail_q] <= bus.write_data;
   end

   assign bus.out_valid = ~empty;
   assign bus.out_data  = mem[head_q];

   always_comb begin
      status            = '0;
      status[PtrW:0]    = count_q;
      status[8]         = empty;
      status[9]         = full;
      status[10]        = ovf_q;
   end

`ifdef MMIO_CYCLE_COUNTER_EN
   logic        hit_cycles;
   logic [31:0] cycles_q;

   assign hit_cycles = (bus.address == BASE + 32'd8);

   always_ff @(posedge clk) begin
      if (reset) begin
         cycles_q <= '0;
      end else if (bus.write && hit_cycles) begin
         cycles_q <= bus.write_data;
      end else begin
         cycles_q <= cycles_q + 32'd1;
      end
   end

   assign bus.sel = hit_data | hit_status | hit_cycles;

   always_comb begin
      bus.read_data = '0;
      if (hit_status) bus.read_data = status;
      if (hit_cycles) bus.read_data = cycles_q;
   end
`else
   assign bus.sel = hit_data | hit_status;

   always_comb begin
      bus.read_data = '0;
      if (hit_status) bus.read_data = status;
   end
`endif

endmodule

// File: tb/tb_mmio_out_port.sv
// Bench for mmio_out_port: queue-based reference model checked every cycle, plus directed
// scenarios with literal expectations.
module tb_mmio_out_port;

   localparam int unsigned DEPTH = 4;
   localparam logic [31:0] BASE  = 32'hFFFF0000;
   localparam logic [31:0] ST    = BASE + 32'd4;
   localparam logic [31:0] CY    = BASE + 32'd8;

   logic clk = 1'b0;
   logic reset;
   int   checks   = 0;
   int   failures = 0;
   bit   cmp_en   = 0;

   mmio_out_port_if bus ();

   mmio_out_port #(
      .DEPTH (DEPTH),
      .BASE  (BASE)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   // Reference model: FIFO as a queue, plus overflow flag and cycle counter.
   logic [31:0] mq[$];
   bit          m_ovf;
   logic [31:0] m_cyc;
   logic [31:0] popped[$];

   always @(posedge clk) begin
      int  n;
      bit  do_pop;
      if (reset) begin
         mq.delete();
         m_ovf = 0;
         m_cyc = 32'd0;
      end else begin
         n      = mq.size();
         do_pop = (n != 0) && bus.out_ready;
         if (do_pop) void'(mq.pop_front());
         if (bus.write && bus.address == BASE) begin
            if (n < DEPTH || do_pop) mq.push_back(bus.write_data);
            else m_ovf = 1;
         end
         if (bus.write && bus.address == ST) m_ovf = 0;
         if (bus.write && bus.address == CY) m_cyc = bus.write_data;
         else m_cyc = m_cyc + 32'd1;
      end
   end

   function automatic logic [32:0] exp_read(input logic [31:0] a);
      logic [31:0] st;
      st = 32'(mq.size()) | (mq.size() == 0 ? 32'h100 : 32'h0)
         | (mq.size() == DEPTH ? 32'h200 : 32'h0) | (m_ovf ? 32'h400 : 32'h0);
      if (a == BASE) return {1'b1, 32'h0};
      if (a == ST)   return {1'b1, st};
`ifdef MMIO_CYCLE_COUNTER_EN
      if (a == CY)   return {1'b1, m_cyc};
`endif
      return {1'b0, 32'h0};
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Per-cycle comparison against the model, and a log of words actually consumed.
   always @(negedge clk) begin
      logic [32:0] e;
      if (cmp_en) begin
         e = exp_read(bus.address);
         check("sel", 32'(bus.sel), 32'(e[32]));
         check("read_data", bus.read_data, e[31:0]);
         check("out_valid", 32'(bus.out_valid), 32'(mq.size() != 0));
         if (mq.size() != 0) check("out_data", bus.out_data, mq[0]);
         if (!reset && bus.out_valid && bus.out_ready) popped.push_back(bus.out_data);
      end
   end

   task automatic drive(input logic w, input logic [31:0] a, input logic [31:0] d,
                        input logic r);
      bus.write      = w;
      bus.address    = a;
      bus.write_data = d;
      bus.out_ready  = r;
      @(posedge clk);
      #1;
      bus.write = 1'b0;
   endtask

   task automatic peek(input logic [31:0] a);
      bus.write   = 1'b0;
      bus.address = a;
      #1;
   endtask

   initial begin
      bus.write      = 1'b0;
      bus.address    = 32'h0;
      bus.write_data = 32'h0;
      bus.out_ready  = 1'b0;
      reset          = 1'b1;
      @(posedge clk);
      #1;
      cmp_en = 1;
      @(posedge clk);
      #1;
      reset = 1'b0;

      peek(ST);
      check("rst_status", bus.read_data, 32'h100);
      check("rst_valid", 32'(bus.out_valid), 32'h0);

      // Three stores held back, then drained back to back.
      drive(1, BASE, 32'h11, 0);
      drive(1, BASE, 32'h22, 0);
      drive(1, BASE, 32'h33, 0);
      peek(ST);
      check("t1_status", bus.read_data, 32'h3);
      check("t1_head", bus.out_data, 32'h11);
      drive(0, ST, 32'h0, 0);
      check("t1_hold", bus.out_data, 32'h11);
      bus.out_ready = 1'b1;
      #1;
      check("t1_pop0", bus.out_data, 32'h11);
      @(posedge clk); #1;
      check("t1_pop1", bus.out_data, 32'h22);
      @(posedge clk); #1;
      check("t1_pop2", bus.out_data, 32'h33);
      @(posedge clk); #1;
      bus.out_ready = 1'b0;
      check("t1_empty", 32'(bus.out_valid), 32'h0);
      peek(ST);
      check("t1_status_end", bus.read_data, 32'h100);

      // Fill, overflow, then clear the sticky flag.
      for (int i = 0; i < 4; i++) drive(1, BASE, 32'hA1 + 32'(i), 0);
      drive(1, BASE, 32'hAA, 0);
      peek(ST);
      check("t2_ovf", bus.read_data, 32'h604);
      drive(1, ST, 32'hDEAD, 0);
      peek(ST);
      check("t2_clr", bus.read_data, 32'h204);

      // Push into a full FIFO while popping on the same edge.
      popped.delete();
      drive(1, BASE, 32'h55, 1);
      peek(ST);
      check("t3_status", bus.read_data, 32'h204);
      bus.out_ready = 1'b1;
      repeat (4) @(posedge clk);
      #1;
      bus.out_ready = 1'b0;
      check("t3_npop", 32'(popped.size()), 32'd5);
      if (popped.size() == 5) begin
         check("t3_w0", popped[0], 32'hA1);
         check("t3_w1", popped[1], 32'hA2);
         check("t3_w2", popped[2], 32'hA3);
         check("t3_w3", popped[3], 32'hA4);
         check("t3_w4", popped[4], 32'h55);
      end
      peek(ST);
      check("t3_status_end", bus.read_data, 32'h100);

      // Cycle counter load and wrap.
`ifdef MMIO_CYCLE_COUNTER_EN
      drive(1, CY, 32'hFFFFFFFE, 0);
      peek(CY);
      check("t4_cy0", bus.read_data, 32'hFFFFFFFE);
      check("t4_sel", 32'(bus.sel), 32'h1);
      @(posedge clk); #1;
      check("t4_cy1", bus.read_data, 32'hFFFFFFFF);
      @(posedge clk); #1;
      check("t4_cy2", bus.read_data, 32'h0);
`else
      drive(1, CY, 32'h1234, 0);
      peek(CY);
      check("t4_rd", bus.read_data, 32'h0);
      check("t4_sel", 32'(bus.sel), 32'h0);
`endif

      // Reset with words queued and a push on the reset edge.
      drive(1, BASE, 32'h61, 0);
      drive(1, BASE, 32'h62, 0);
      drive(1, BASE, 32'h63, 0);
      reset          = 1'b1;
      bus.write      = 1'b1;
      bus.address    = BASE;
      bus.write_data = 32'h99;
      bus.out_ready  = 1'b1;
      @(posedge clk); #1;
      reset         = 1'b0;
      bus.write     = 1'b0;
      bus.out_ready = 1'b0;
      check("t5_valid", 32'(bus.out_valid), 32'h0);
      peek(ST);
      check("t5_status", bus.read_data, 32'h100);
`ifdef MMIO_CYCLE_COUNTER_EN
      peek(CY);
      check("t5_cycles", bus.read_data, 32'h0);
`endif
      drive(1, BASE, 32'h77, 0);
      check("t5_head", bus.out_data, 32'h77);

      // Store outside the window is ignored.
      drive(1, 32'h00000010, 32'h88, 0);
      peek(32'h00000010);
      check("t6_sel", 32'(bus.sel), 32'h0);
      check("t6_rd", bus.read_data, 32'h0);
      peek(ST);
      check("t6_status", bus.read_data, 32'h1);
      check("t6_head", bus.out_data, 32'h77);
      drive(0, ST, 32'h0, 1);
      drive(0, ST, 32'h0, 1);
      peek(ST);
      check("t6_status_end", bus.read_data, 32'h100);

      repeat (2) @(posedge clk);
      #1;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/mmio_out_port.md
# mmio_out_port

Memory-mapped output peripheral on the data-memory side of the single-cycle MIPS core. It decodes the core's data-memory address, write enable and write data, and captures `sw` stores to its window into a DEPTH-entry FIFO. The FIFO drains to an external consumer over a valid/ready handshake. Status and cycle-counter registers are readable through a combinational read port, which the top level muxes ahead of `dmem` read data using `sel`.

## Interface
- `DEPTH`, 4: FIFO entries; power of two, 2..128.
- `BASE`, 32'hFFFF0000: window base. Register offsets: +0 DATA, +4 STATUS, +8 CYCLES.
- `clk` input 1: rising-edge clock.
- `reset` input 1: synchronous, active-high reset.
- `write` input 1: store strobe, the core's MemWrite.
- `address` input 32: byte address, the core's ALU result.
- `write_data` input 32: store data, the core's rt register value.
- `read_data` output 32: combinational read of the addressed register.
- `sel` output 1: combinational; 1 when `address` is BASE, BASE+4 or BASE+8.
- `out_valid` output 1: FIFO non-empty.
- `out_data` output 32: FIFO head word.
- `out_ready` input 1: consumer accepts the head word.

## Operation
- Decode is a full 32-bit compare against BASE, BASE+4 and BASE+8 only. Every other address gives `sel`=0 and `read_data`=0, and this block takes no action on writes to it.
- FIFO storage:
  - Circular buffer with head and tail pointers of log2(DEPTH) bits, which wrap modulo DEPTH.
  - Count is log2(DEPTH)+1 bits.
- Push: `write` & address==BASE at a clock edge.
  - If not full, or a pop occurs on the same edge, `write_data` goes to the tail and tail advances.
  - Otherwise the word is dropped and sticky `ovf` is set.
- Pop: `out_valid` & `out_ready` at a clock edge; head advances.
- Push and pop on the same edge:
  - Both take effect and count is unchanged.
  - This applies when full (the push is accepted) and when empty (no pop occurs, so it is a push only).
- `out_valid` = count!=0. `out_data` = mem[head]; it is don't-care when empty but must hold stable while `out_valid` & !`out_ready`.
- STATUS read value:
  - [7:0] count, zero-extended.
  - [8] empty.
  - [9] full.
  - [10] `ovf`.
  - Other bits 0.
- A write to BASE+4 (any data) clears `ovf`. If a dropped push could also set it on that edge, clear wins; this cannot occur, since the two writes target different addresses.
- Reads have no side effects. A read of DATA returns 0 and does not pop.
- CYCLES is a 32-bit free-running counter that increments every cycle and wraps 32'hFFFFFFFF→0. A write to BASE+8 loads `write_data`, and the load takes precedence over the increment on that edge.

## Timing
- Reset, synchronous and active-high, applied on any cycle including mid-transfer:
  - count=0, head=tail=0, `ovf`=0, CYCLES=0.
  - `out_valid`=0; `out_data` don't-care.
  - FIFO contents are not cleared.
  - Pushes and pops on the reset edge are discarded.
- `read_data` and `sel` are combinational from `address` and state. State changes become visible after the edge, giving the same-cycle read semantics as async memory.
- Push-to-`out_valid` latency: a store accepted at edge N raises `out_valid` after edge N.
- Throughput: one push and one pop per cycle, sustained.
- A word is consumed only on an edge where `out_valid` & `out_ready` are both 1. `out_ready` may be held high while empty with no effect.

## Configuration
- `MMIO_CYCLE_COUNTER_EN` defined: the CYCLES register and counter are implemented as above.
- Undefined:
  - No counter flops.
  - `sel` covers only BASE and BASE+4.
  - BASE+8 reads 0 with `sel`=0, and writes to it are ignored.

## Test plan
- Reset, then store 32'h11, 32'h22, 32'h33 to BASE with `out_ready`=0. Required: STATUS reads 32'h3, and `out_data`=32'h11 stays stable. Then with `out_ready`=1, words 11/22/33 pop on three consecutive edges, after which STATUS=32'h100.
- Fill with DEPTH=4 and store 32'hAA while `out_ready`=0. Required: STATUS=32'h604 and 32'hAA is never emitted. Then a write to BASE+4 gives STATUS=32'h204.
- Full FIFO, store 32'h55 with `out_ready`=1 on the same edge. Required: count stays 4, no `ovf`, and 32'h55 is emitted last after the 5 total pops. This also exercises pointer wrap.
- Store 32'hFFFFFFFE to BASE+8 (macro defined). Required: reads return FFFFFFFE, FFFFFFFF, 00000000 on the next edges. Without the macro, the read returns 0 and `sel`=0.
- Assert `reset` with 3 words queued and a push on the same edge. Required: the next cycle shows `out_valid`=0, STATUS=32'h100, and CYCLES=0.
- Store to address 32'h00000010. Required: `sel`=0, `read_data`=0, FIFO unchanged.
